stream_fifo_share_arb: RTL

- Round-robin arbiter sharing one deep StreamingFIFO (Q_srl-based, count output) between NUM_REQ AXI-Stream producers.
- Grants are burst-atomic: BURST_LEN beats per grant.
- A burst is granted only when the FIFO has space reserved for the whole burst, so one stalled producer cannot wedge the shared buffer mid-burst.
- Sits between parallel FINN layer outputs and the shared FIFO's in0_V port; an ID sideband tags each beat's source.

---
 rtl/stream_arb_pkg.sv | 31 +++
 rtl/rr_pick.sv | 39 +++
 rtl/stream_fifo_share_arb.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/stream_arb_pkg.sv
// ---------------------------------------------------------------------------
// stream_arb_pkg
// Shared types and helpers for the stream_fifo_share_arb block.
//   arbState_e  : arbiter state (IDLE waits for space and a request,
//                 BURST streams one burst from the granted requester)
//   NUM_REQ_MAX : largest supported requester count
//   STAT_W      : width of each statistics counter (STREAM_ARB_STATS_EN)
//   clog2()     : index width helper, never returns less than 1
// ---------------------------------------------------------------------------
package stream_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arbState_e;

  localparam int NUM_REQ_MAX = 8;
  localparam int STAT_W      = 16;

  // Width needed to index 'value' items; one bit minimum so that
  // single-entry selections still get a real signal.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first asserted request at
// or above ptr_i, wrapping around past the top index.
// Ports:
//   req_i   [NUM_REQ-1:0]  request vector
//   ptr_i   [ID_W-1:0]     index with highest priority this round
//   idx_o   [ID_W-1:0]     selected index (0 when nothing is requested)
//   found_o                high when at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               found_o
);

  // Walk the requesters starting at the pointer; the first hit wins and
  // later hits are ignored because found_o is already set.
  always_comb begin
    int cand;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_fifo_share_arb.sv
// ---------------------------------------------------------------------------
// stream_fifo_share_arb
// Round-robin, burst-atomic arbiter that lets NUM_REQ AXI-Stream producers
// share one deep downstream FIFO. A burst of BURST_LEN beats is granted only
// when the FIFO already has room for all of it, so a producer that stalls
// mid-burst can never leave the shared buffer wedged half full of its data.
//
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   in_TDATA  [NUM_REQ*WIDTH] packed requester data, req i at [i*WIDTH +: WIDTH]
//   in_TVALID [NUM_REQ]       per-requester valid
//   in_TREADY [NUM_REQ]       per-requester ready (only the granted one)
//   out_V_TDATA/TVALID/TREADY stream toward the FIFO in0_V port
//   out_id    [ID_W]          source index of the current beat
//   fifo_count [CNT_W]        FIFO occupancy, looked at only while idle
//   busy                      high while a burst is in progress
//
// Optional build macro STREAM_ARB_STATS_EN adds:
//   grant_cnt [NUM_REQ*16]    per-requester saturating completed-burst counts
//   stall_cnt [16]            saturating count of BURST cycles without valid
// ---------------------------------------------------------------------------
module stream_fifo_share_arb
  import stream_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  WIDTH     = 16,
  parameter int  DEPTH     = 5184,
  parameter int  CNT_W     = 13,
  parameter int  BURST_LEN = 64,
  localparam int ID_W      = clog2(NUM_REQ)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NUM_REQ*WIDTH-1:0] in_TDATA,
  input  logic [NUM_REQ-1:0]       in_TVALID,
  output logic [NUM_REQ-1:0]       in_TREADY,
  output logic [WIDTH-1:0]         out_V_TDATA,
  output logic                     out_V_TVALID,
  input  logic                     out_V_TREADY,
  output logic [ID_W-1:0]          out_id,
  input  logic [CNT_W-1:0]         fifo_count,
  output logic                     busy
`ifdef STREAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt,
  output logic [STAT_W-1:0]         stall_cnt
`endif
);

  localparam int              BEAT_W    = clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W:0]  DEPTH_EXT = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W:0]  BURST_EXT = (CNT_W + 1)'(BURST_LEN);
  localparam logic [ID_W-1:0] TOP_ID    = ID_W'(NUM_REQ - 1);

  arbState_e         state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
  logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;
  logic [WIDTH-1:0]  lastData_q;

  logic [WIDTH-1:0]  reqData [NUM_REQ];
  logic [WIDTH-1:0]  selData;
  logic              selValid;
  logic              spaceOk;
  logic [CNT_W:0]    countExt;
  logic [ID_W-1:0]   pickIdx;
  logic              pickFound;
  logic              burstDone;

  // Unpack the flat data bus so the granted lane can be indexed directly.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqData[i] = in_TDATA[i*WIDTH +: WIDTH];
    end
  end

  assign selData  = reqData[grant_q];
  assign selValid = in_TVALID[grant_q];

  // Free space is computed one bit wider than the count so the subtraction
  // cannot wrap; a count reported above DEPTH is treated as "no room".
  assign countExt = {1'b0, fifo_count};
  assign spaceOk  = (countExt <= DEPTH_EXT) && ((DEPTH_EXT - countExt) >= BURST_EXT);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_i   (in_TVALID),
    .ptr_i   (rrPtr_q),
    .idx_o   (pickIdx),
    .found_o (pickFound)
  );

  // State, grant, beat counter and round-robin pointer registers. The last
  // presented data word is kept so the output bus holds steady while idle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rrPtr_q    <= '0;
      beatCnt_q  <= '0;
      lastData_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rrPtr_q   <= rrPtr_d;
      beatCnt_q <= beatCnt_d;
      if (state_q == BURST) begin
        lastData_q <= selData;
      end
    end
  end

  // Next-state and stream steering. In BURST the granted lane is wired
  // straight through; a dropped TVALID simply stalls the burst while the
  // grant is held. Only completed bursts advance the round-robin pointer,
  // past the requester just served.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rrPtr_d      = rrPtr_q;
    beatCnt_d    = beatCnt_q;
    in_TREADY    = '0;
    out_V_TVALID = 1'b0;
    out_V_TDATA  = lastData_q;
    busy         = 1'b0;
    burstDone    = 1'b0;
    case (state_q)
      IDLE: begin
        if (spaceOk && pickFound) begin
          grant_d   = pickIdx;
          beatCnt_d = '0;
          state_d   = BURST;
        end
      end
      BURST: begin
        busy               = 1'b1;
        out_V_TVALID       = selValid;
        out_V_TDATA        = selData;
        in_TREADY[grant_q] = out_V_TREADY;
        if (selValid && out_V_TREADY) begin
          if (beatCnt_q == LAST_BEAT) begin
            burstDone = 1'b1;
            beatCnt_d = '0;
            state_d   = IDLE;
            rrPtr_d   = (grant_q == TOP_ID) ? '0 : grant_q + ID_W'(1);
          end else begin
            beatCnt_d = beatCnt_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_id = grant_q;

`ifdef STREAM_ARB_STATS_EN
  logic [STAT_W-1:0] grantCnt_q [NUM_REQ];
  logic [STAT_W-1:0] stallCnt_q;

  // Saturating statistics: completed bursts per requester and BURST cycles
  // in which the granted producer had nothing to offer.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grantCnt_q[i] <= '0;
      end
      stallCnt_q <= '0;
    end else begin
      if (burstDone && (grantCnt_q[grant_q] != '1)) begin
        grantCnt_q[grant_q] <= grantCnt_q[grant_q] + STAT_W'(1);
      end
      if ((state_q == BURST) && !selValid && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + STAT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*STAT_W +: STAT_W] = grantCnt_q[i];
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule
